chunked_add_seq: RTL



---
 rtl/chunked_add_seq.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/chunked_add_seq.sv
// ---------------------------------------------------------------------------
// chunked_add_seq -- multi-cycle wide adder sequencer
//
// Adds two CHUNKS*WIDTH-bit operands one WIDTH-bit chunk per clock through a
// single ripple `adder`. The carry out of each chunk is registered and fed
// into the next chunk, so the combinational carry chain never exceeds WIDTH
// bits. A start/busy/done handshake frames each operation.
//
// Optional feature: define CHUNKED_ADD_OVF_EN to add the Ovf port and the
// signed-overflow flag. Without it there is no Ovf port and no overflow logic.
//
// Ports:
//   Clk    in   1             clock, rising edge
//   Rst    in   1             asynchronous active-high reset
//   Start  in   1             request an addition (sampled only when idle)
//   A, B   in   WIDTH*CHUNKS  operands, latched when Start is accepted
//   Cin    in   1             carry into chunk 0, latched with the operands
//   Busy   out  1             high while chunks are being summed
//   Done   out  1             one-cycle pulse; Sum/Cout are final
//   Sum    out  WIDTH*CHUNKS  registered result
//   Cout   out  1             registered carry out of the top chunk
//   Ovf    out  1             signed overflow (CHUNKED_ADD_OVF_EN only)
// ---------------------------------------------------------------------------

// Parameterized ripple-carry adder: one full adder per bit.
module adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    logic [WIDTH:0] c;

    assign c[0] = Cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign Sum[gi]  = A[gi] ^ B[gi] ^ c[gi];
            assign c[gi+1]  = (A[gi] & B[gi]) | (c[gi] & (A[gi] ^ B[gi]));
        end
    endgenerate

    assign Cout = c[WIDTH];
endmodule

module chunked_add_seq #(
    parameter int WIDTH  = 8,
    parameter int CHUNKS = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Start,
    input  logic [WIDTH*CHUNKS-1:0] A,
    input  logic [WIDTH*CHUNKS-1:0] B,
    input  logic                    Cin,
    output logic                    Busy,
    output logic                    Done,
    output logic [WIDTH*CHUNKS-1:0] Sum,
`ifdef CHUNKED_ADD_OVF_EN
    output logic                    Ovf,
`endif
    output logic                    Cout
);
    localparam int TOTAL = WIDTH * CHUNKS;
    // Keep the index at least one bit wide so CHUNKS=1 still elaborates.
    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [TOTAL-1:0]   a_reg, a_next;
    logic [TOTAL-1:0]   b_reg, b_next;
    logic [TOTAL-1:0]   sum_reg, sum_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               carry_reg, carry_next;
    logic               cout_reg, cout_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
`ifdef CHUNKED_ADD_OVF_EN
    logic               ovf_reg, ovf_next;
`endif

    // Operands split into chunks so the current chunk is picked with a
    // constant-slice mux rather than a variable part-select.
    logic [WIDTH-1:0]   a_chunk [CHUNKS];
    logic [WIDTH-1:0]   b_chunk [CHUNKS];
    logic [WIDTH-1:0]   a_cur, b_cur;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    generate
        for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_chunk
            assign a_chunk[gi] = a_reg[gi*WIDTH +: WIDTH];
            assign b_chunk[gi] = b_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        a_cur = a_chunk[0];
        b_cur = b_chunk[0];
        for (int i = 1; i < CHUNKS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                a_cur = a_chunk[i];
                b_cur = b_chunk[i];
            end
        end
    end

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .A    (a_cur),
        .B    (b_cur),
        .Cin  (carry_reg),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        idx_next   = idx_reg;
        carry_next = carry_reg;
        cout_next  = cout_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;       // Done is a single-cycle pulse
`ifdef CHUNKED_ADD_OVF_EN
        ovf_next   = ovf_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (Start) begin
                    a_next     = A;
                    b_next     = B;
                    carry_next = Cin;
                    idx_next   = '0;
                    sum_next   = '0;
                    cout_next  = 1'b0;
                    busy_next  = 1'b1;
`ifdef CHUNKED_ADD_OVF_EN
                    ovf_next   = 1'b0;
`endif
                    state_next = RUN;
                end
            end

            RUN: begin
                // Only the chunk being processed is written; lower chunks
                // already hold their final value.
                for (int i = 0; i < CHUNKS; i++) begin
                    if (idx_reg == IDX_W'(i)) begin
                        sum_next[i*WIDTH +: WIDTH] = add_sum;
                    end
                end
                carry_next = add_cout;
                idx_next   = idx_reg + IDX_W'(1);

                if (idx_reg == LAST_IDX) begin
                    cout_next  = add_cout;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    idx_next   = '0;
`ifdef CHUNKED_ADD_OVF_EN
                    // The result MSB is the MSB of the top chunk's sum.
                    ovf_next   = (a_reg[TOTAL-1] == b_reg[TOTAL-1]) &&
                                 (add_sum[WIDTH-1] != a_reg[TOTAL-1]);
`endif
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef CHUNKED_ADD_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            idx_reg   <= idx_next;
            carry_reg <= carry_next;
            cout_reg  <= cout_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
`ifdef CHUNKED_ADD_OVF_EN
            ovf_reg   <= ovf_next;
`endif
        end
    end

    assign Busy = busy_reg;
    assign Done = done_reg;
    assign Sum  = sum_reg;
    assign Cout = cout_reg;
`ifdef CHUNKED_ADD_OVF_EN
    assign Ovf  = ovf_reg;
`endif

endmodule
